// File: rtl/udp_tx_arbiter.sv
// Shares the MAC UDP transmit port between NUM_REQ packet sources, one packet per grant.
// Define UDP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module udp_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  have_ip,
  input  logic [NUM_REQ-1:0]    req_request,
  input  logic [11*NUM_REQ-1:0] req_length,
  input  logic [8*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]    req_enable,
  output logic                  udp_tx_request,
  input  logic                  udp_tx_enable,
  output logic [10:0]           udp_tx_length,
  output logic [7:0]            udp_tx_data,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, GAP = 2'd3} state_e;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  state_e             state_q;
  logic [1:0]         grant_q;
  logic [1:0]         ptr_q;
  logic [10:0]        cnt_q;
  logic [10:0]        len_q;
  logic [7:0]         gap_q;
  logic [1:0]         win_s;
  logic [1:0]         ptr_next_s;
  logic               found_s;
  logic [10:0]        sel_len_s;
  logic [7:0]         sel_data_s;
  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] gnt_oh_s;

  // Granted-requester mux and round-robin winner search starting at the pointer.
  always_comb begin
    sel_len_s  = 11'd0;
    sel_data_s = 8'd0;
    gnt_oh_s   = '0;
    elig_s     = '0;
    found_s    = 1'b0;
    win_s      = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      elig_s[k] = req_request[k] && (req_length[11*k +: 11] != 11'd0);
      if (grant_q == 2'(k)) begin
        sel_len_s   = req_length[11*k +: 11];
        sel_data_s  = req_data[8*k +: 8];
        gnt_oh_s[k] = 1'b1;
      end else begin
        gnt_oh_s[k] = 1'b0;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && elig_s[k] && (k >= int'(ptr_q))) begin
        found_s = 1'b1;
        win_s   = 2'(k);
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && elig_s[k]) begin
        found_s = 1'b1;
        win_s   = 2'(k);
      end else begin
        found_s = found_s;
      end
    end
  end

`ifdef UDP_ARB_FIXED_PRIO_EN
  assign ptr_next_s = 2'd0;
`else
  assign ptr_next_s = (grant_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_q + 2'd1;
`endif

  // Arbitration FSM with byte and gap counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 11'd0;
      len_q   <= 11'd0;
      gap_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (have_ip && found_s) begin
            grant_q <= win_s;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (udp_tx_enable) begin
            cnt_q   <= sel_len_s;
            len_q   <= sel_len_s;
            ptr_q   <= ptr_next_s;
            state_q <= XFER;
          end else if ((req_request & gnt_oh_s) == '0) begin
            state_q <= IDLE;
          end
        end
        XFER: begin
          cnt_q <= cnt_q - 11'd1;
          if (cnt_q == 11'd1) begin
            gap_q   <= GAP_LOAD;
            state_q <= GAP;
          end
        end
        GAP: begin
          // GAP_CYCLES of 0 or 1 both give a single GAP cycle
          if (gap_q <= 8'd1) begin
            gap_q   <= 8'd0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // MAC-side outputs decoded from state; enable is forwarded with zero latency.
  always_comb begin
    udp_tx_request = (state_q == REQ);
    busy           = (state_q != IDLE);
    if ((state_q == REQ) && udp_tx_enable) begin
      req_enable = gnt_oh_s;
    end else begin
      req_enable = '0;
    end
    case (state_q)
      REQ: begin
        udp_tx_length = sel_len_s;
        udp_tx_data   = 8'd0;
      end
      XFER: begin
        udp_tx_length = len_q;
        udp_tx_data   = sel_data_s;
      end
      default: begin
        udp_tx_length = 11'd0;
        udp_tx_data   = 8'd0;
      end
    endcase
  end

  assign grant = grant_q;

endmodule
